uart_loopback_buffer: RTL and testbench
=======================================

// Module: uart_loopback_buffer
//
// PURPOSE
// - Byte buffer between the UART receiver and the UART transmitter in tt_um_uart_bgdtanasa.
// - Accepts each byte the RX presents with its 1-cycle strobe and stores it in a FIFO.
// - Launches the TX one byte at a time and waits for TX completion before launching the next.
// - Absorbs back-to-back RX frames while TX is busy, and flags bytes lost to overflow.
//
// PARAMETERS
// - DATA_W  8  byte width
// - DEPTH   8  FIFO entries; must be a power of 2, >= 2
// - ADDR_W  $clog2(DEPTH)  localparam; pointer width
//
// PORTS
// - clk           in   1         system clock; all logic on posedge
// - rst_n         in   1         asynchronous, active-low reset
// - rx_data       in   DATA_W    received byte; valid only while rx_valid = 1
// - rx_valid      in   1         1-cycle strobe from RX (rx_data_ready)
// - tx_busy       in   1         TX is serialising a frame
// - tx_done       in   1         1-cycle strobe from TX at the end of the stop bit
// - clr_overflow  in   1         synchronous clear of the overflow flag
// - tx_data       out  DATA_W    byte for TX; held stable from tx_start until tx_done
// - tx_start      out  1         1-cycle launch strobe to TX
// - level         out  ADDR_W+1  FIFO occupancy, 0..DEPTH
// - empty         out  1         level == 0
// - full          out  1         level == DEPTH
// - overflow      out  1         sticky; a push was dropped
//
// BEHAVIOUR
// - Reset values (async, while rst_n = 0):
//   - outputs: tx_data = 0, tx_start = 0, level = 0, empty = 1, full = 0, overflow = 0
//   - internal: pointers = 0, state = IDLE
//   - storage RAM is not reset.
// - Push: on a cycle with rx_valid = 1, the byte is accepted if (!full || pop_this_cycle).
//   - Accepted: written at wr_ptr; wr_ptr increments mod DEPTH.
//   - Not accepted: byte dropped and overflow <= 1.
// - Pointers and flags:
//   - Pointers are ADDR_W bits and wrap naturally.
//   - level is a separate up/down counter: +1 on push only, -1 on pop only, unchanged on push and pop together.
//   - empty and full are decoded from level and registered with it, so they update 1 cycle after the event.
// - Overflow flag:
//   - clr_overflow clears the flag.
//   - If a drop and clr_overflow occur in the same cycle, set wins (overflow = 1).
// - Transmit FSM states: IDLE, LAUNCH, WAIT_DONE.
//   - IDLE -> LAUNCH when !empty && !tx_busy.
//     - pop_this_cycle = 1.
//     - tx_data <= mem[rd_ptr]; rd_ptr increments.
//   - LAUNCH: tx_start = 1 for exactly this cycle; next state WAIT_DONE.
//   - WAIT_DONE -> IDLE on tx_done = 1.
//   - tx_done outside WAIT_DONE is ignored.
//   - tx_busy is not checked in LAUNCH or WAIT_DONE.
// - Latency:
//   - rx_valid at cycle N -> empty = 0 at N+1 -> pop at N+1 -> tx_start at N+2 (if TX idle).
//   - tx_done at cycle M -> IDLE at M+1 -> next tx_start at M+2 (if not empty).
// - Ordering: strict FIFO; no byte is duplicated or reordered.
// - Reset mid-frame: everything returns to its reset values immediately.
//   - In-flight TX byte and queued bytes are discarded.
//   - A later stray tx_done is ignored (state is IDLE).
// - A second rx_valid in consecutive cycles is legal; each strobe is one push.
//
// STRUCTURE
// - uart_pkg (shared package):
//   - typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} uart_lb_state_t
//   - localparam UART_DATA_W = 8
// - Sub-module uart_byte_fifo:
//   - contains storage, wr/rd pointers, level, full/empty and the same-cycle push/pop rule
//   - exposes push/pop/din/dout
// - The top of this block holds the transmit FSM, the tx_data register and the overflow flag.
//
// TESTING
// - Test 1, single byte after reset:
//   - stimulus: rx 0x55, TX idle
//   - required: tx_start exactly 2 cycles after rx_valid, with tx_data = 0x55
//   - required: level 0->1->0; no second tx_start before tx_done
// - Test 2, ordering:
//   - stimulus: 0x55, 0x5A, 0x97, 0xAA, 0xFF, 0x01 pushed back-to-back while tx_busy = 1
//   - required: level = 6, then the TX receives the bytes in exactly that order, one per tx_done
// - Test 3, full boundary:
//   - stimulus: push 8 bytes with TX stalled (no tx_done), then a 9th
//   - required: full = 1 after the 8th push, the 9th is dropped, overflow = 1
//   - then: clr_overflow returns overflow to 0 and full remains 1
// - Test 4, simultaneous push and pop at full:
//   - stimulus: rx_valid in the same cycle the FSM pops
//   - required: byte accepted, level stays 8, overflow stays 0
//   - required: pointers wrap correctly over 3 full cycles of DEPTH
// - Test 5, reset mid-operation:
//   - stimulus: assert rst_n = 0 during WAIT_DONE with 3 bytes queued
//   - required: all outputs reset within the same cycle
//   - then: a tx_done after release produces no tx_start; the next rx 0xA5 is sent normally
// - Test 6, tx_done and overflow edge cases:
//   - stimulus: tx_done pulsed in IDLE
//   - required: ignored
//   - stimulus: drop coincident with clr_overflow
//   - required: overflow = 1

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_pkg
// Description : Shared types and constants for the UART loopback buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } uart_lb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_fifo
// Description : Byte FIFO with registered level/empty/full. A push at full is
//               accepted only when a pop happens in the same cycle; otherwise
//               it is reported on drop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W = UART_DATA_W,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              drop,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_next;
  logic              do_push;
  logic              do_pop;

  // A pop frees a slot in the same cycle, so a push at full still fits.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = mem[rd_ptr];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Read/write pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy up/down counter; push and pop together leave it unchanged.
  always_comb begin
    level_next = level;
    case ({do_push, do_pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Level and its decoded flags are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      level <= level_next;
      empty <= (level_next == '0);
      full  <= (level_next == FULL_LEVEL);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_loopback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_loopback_buffer
// Description : Buffers bytes from the UART receiver and feeds them to the
//               UART transmitter one frame at a time, with a sticky overflow
//               flag for bytes dropped at full.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_loopback_buffer
  import uart_pkg::*;
#(
  parameter  int DATA_W = UART_DATA_W,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  input  logic              tx_done,
  input  logic              clr_overflow,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  uart_lb_state_t    state;
  uart_lb_state_t    state_next;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] fifo_dout;

  uart_byte_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_valid),
    .pop   (pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .drop  (drop),
    .level (level),
    .empty (empty),
    .full  (full)
  );

  // Transmit FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: launch when a byte is waiting and TX is free, then wait for done.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!empty && !tx_busy) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // FSM outputs: the pop accompanies the IDLE->LAUNCH move; tx_start marks LAUNCH.
  always_comb begin
    pop      = (state == IDLE) && !empty && !tx_busy;
    tx_start = (state == LAUNCH);
  end

  // Capture the head byte at pop and hold it for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   tx_data <= '0;
    else if (pop) tx_data <= fifo_dout;
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_loopback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_loopback_buffer
// Description : Scenario bench for uart_loopback_buffer with a byte
//               scoreboard queue filled on push and drained on tx_start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_loopback_buffer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [3:0] level;
  logic       empty;
  logic       full;
  logic       overflow;

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] q [$];

  uart_loopback_buffer #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .clr_overflow (clr_overflow),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0; tx_busy = 1'b0; tx_done = 1'b0; clr_overflow = 1'b0; rx_data = '0;
    q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One-cycle rx strobe; accepted bytes are recorded in the scoreboard.
  task automatic push_byte(input logic [7:0] b, input bit accepted);
    rx_data  = b;
    rx_valid = 1'b1;
    if (accepted) q.push_back(b);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // From LAUNCH: move into WAIT_DONE, then pulse tx_done back to IDLE.
  task automatic finish_frame();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tx_data, tx_start, level, empty, full, overflow} !== {8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: got data=%h start=%b level=%0d empty=%b full=%b ovf=%b, expected 00 0 0 1 0 0",
               tx_data, tx_start, level, empty, full, overflow);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp;
    int extra;
    do_reset();
    push_byte(8'h55, 1'b1);
    checks++;
    if (level !== 4'd1 || empty !== 1'b0 || tx_start !== 1'b0) begin
      fails++;
      $display("FAIL single_after_push: got level=%0d empty=%b start=%b, expected 1 0 0", level, empty, tx_start);
    end
    tick();
    exp = q.pop_front();
    checks++;
    if (tx_start !== 1'b1 || tx_data !== exp || level !== 4'd0) begin
      fails++;
      $display("FAIL single_launch: got start=%b data=%h level=%0d, expected 1 %h 0", tx_start, tx_data, level, exp);
    end
    extra = 0;
    repeat (6) begin
      tick();
      if (tx_start !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL single_no_second_start: got %0d extra starts, expected 0", extra);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_ordering();
    logic [7:0] pat [6];
    logic [7:0] exp;
    bit seen;
    pat = '{8'h55, 8'h5A, 8'h97, 8'hAA, 8'hFF, 8'h01};
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) push_byte(pat[i], 1'b1);
    checks++;
    if (level !== 4'd6) begin
      fails++;
      $display("FAIL order_level: got %0d expected 6", level);
    end
    tx_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_start(seen);
      checks++;
      if (!seen) begin
        fails++;
        $display("FAIL order_start_%0d: got no tx_start, expected one", i);
        break;
      end
      exp = q.pop_front();
      checks++;
      if (tx_data !== exp) begin
        fails++;
        $display("FAIL order_data_%0d: got %h expected %h", i, tx_data, exp);
      end
      finish_frame();
    end
    tick();
    tick();
    checks++;
    if (level !== 4'd0 || empty !== 1'b1 || tx_start !== 1'b0) begin
      fails++;
      $display("FAIL order_drained: got level=%0d empty=%b start=%b, expected 0 1 0", level, empty, tx_start);
    end
  endtask

  task automatic test_full();
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i), 1'b1);
    checks++;
    if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_after_8: got full=%b level=%0d ovf=%b, expected 1 8 0", full, level, overflow);
    end
    push_byte(8'hEE, 1'b0);
    checks++;
    if (overflow !== 1'b1 || level !== 4'd8 || full !== 1'b1) begin
      fails++;
      $display("FAIL full_drop_9th: got ovf=%b level=%0d full=%b, expected 1 8 1", overflow, level, full);
    end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      fails++;
      $display("FAIL full_clear_ovf: got ovf=%b full=%b, expected 0 1", overflow, full);
    end
  endtask

  // Continues from the full FIFO left by test_full (IDLE, tx_busy high).
  task automatic test_push_pop_full();
    logic [7:0] b;
    logic [7:0] exp;
    for (int it = 0; it < 3 * DEPTH; it++) begin
      b = 8'($urandom_range(0, 255));
      tx_busy  = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      q.push_back(b);
      tick();
      rx_valid = 1'b0;
      tx_busy  = 1'b1;
      checks++;
      if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
        fails++;
        $display("FAIL pp_level_%0d: got level=%0d full=%b ovf=%b, expected 8 1 0", it, level, full, overflow);
      end
      exp = q.pop_front();
      checks++;
      if (tx_start !== 1'b1 || tx_data !== exp) begin
        fails++;
        $display("FAIL pp_data_%0d: got start=%b data=%h, expected 1 %h", it, tx_start, tx_data, exp);
      end
      finish_frame();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    bit seen;
    int extra;
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h31 + i), 1'b1);
    tx_busy = 1'b0;
    wait_start(seen);
    exp = q.pop_front();
    checks++;
    if (!seen || tx_data !== exp) begin
      fails++;
      $display("FAIL rst_first_launch: got seen=%b data=%h, expected 1 %h", seen, tx_data, exp);
    end
    tick();
    checks++;
    if (level !== 4'd3) begin
      fails++;
      $display("FAIL rst_queued: got level=%0d expected 3", level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_data, tx_start, level, empty, full, overflow} !== {8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL rst_async_values: got data=%h start=%b level=%0d empty=%b full=%b ovf=%b, expected 00 0 0 1 0 0",
               tx_data, tx_start, level, empty, full, overflow);
    end
    q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    extra = 0;
    repeat (6) begin
      tick();
      if (tx_start !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0 || level !== 4'd0) begin
      fails++;
      $display("FAIL rst_stray_done: got %0d starts level=%0d, expected 0 0", extra, level);
    end
    push_byte(8'hA5, 1'b1);
    wait_start(seen);
    exp = q.pop_front();
    checks++;
    if (!seen || tx_data !== exp) begin
      fails++;
      $display("FAIL rst_next_byte: got seen=%b data=%h, expected 1 %h", seen, tx_data, exp);
    end
    finish_frame();
  endtask

  task automatic test_edge_cases();
    logic [7:0] exp;
    bit seen;
    int extra;
    tx_busy = 1'b1;
    push_byte(8'h66, 1'b1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    extra = 0;
    repeat (5) begin
      tick();
      if (tx_start !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0 || level !== 4'd1) begin
      fails++;
      $display("FAIL edge_done_in_idle: got %0d starts level=%0d, expected 0 1", extra, level);
    end
    for (int i = 0; i < DEPTH - 1; i++) push_byte(8'(8'hC0 + i), 1'b1);
    rx_data = 8'hDD;
    rx_valid = 1'b1;
    clr_overflow = 1'b1;
    tick();
    rx_valid = 1'b0;
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 4'd8) begin
      fails++;
      $display("FAIL edge_drop_and_clear: got ovf=%b level=%0d, expected 1 8", overflow, level);
    end
    tx_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wait_start(seen);
      exp = q.pop_front();
      checks++;
      if (!seen || tx_data !== exp) begin
        fails++;
        $display("FAIL edge_drain_%0d: got seen=%b data=%h, expected 1 %h", i, seen, tx_data, exp);
      end
      finish_frame();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ordering();
    test_full();
    test_push_pop_full();
    test_reset_mid();
    test_edge_cases();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
